systolic_feed_ram: RTL and testbench

- Parametrised successor to the single-bank operand RAM.
- Holds one operand bank per systolic-array row/column channel.
- Accepts host writes at any time. On a start command, streams a contiguous address window out of every bank in parallel, with the per-channel diagonal skew the PE array needs.
- Sits between the load path and the edge PEs of the systolic array; replaces the hand-initialised per-channel RAMs.

---
 rtl/systolic_feed_ram_pkg.sv | 19 +
 rtl/systolic_feed_ram_bank.sv | 28 ++
 rtl/systolic_feed_ram.sv | 175 +++++++++++++++++
 tb/tb_systolic_feed_ram.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feed_ram_pkg.sv
// Shared defaults, FSM state type and lane-slice helper for the systolic operand feed RAM.
package systolic_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int DEPTH_DEF    = 16;
    localparam int CHANNELS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feed_state_t;

    // LSB of lane c inside a flattened bus of width-w lanes.
    function automatic int lane_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/systolic_feed_ram_bank.sv
// One operand bank: read-first, enable-gated synchronous RAM with a registered read word.
module feed_bank #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/systolic_feed_ram.sv
// Multi-bank operand feed for a systolic array edge; streams a window from every bank in parallel.
// Define SYSTOLIC_FEED_SKEW_EN to delay lane c by c cycles for the diagonal wavefront.
module systolic_feed_ram
    import systolic_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base,
    input  logic [ADDR_W:0]           len,
    input  logic                      hold,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data
);

`ifdef SYSTOLIC_FEED_SKEW_EN
    localparam int DRAIN_CYCLES = CHANNELS;
`else
    localparam int DRAIN_CYCLES = 1;
`endif
    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    feed_state_t state, next_state;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt;
    logic [DC_W-1:0]   drain_cnt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              v0;
    logic [WIDTH-1:0]  bank_q [CHANNELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (!hold) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && (len != '0)) next_state = RUN;
            RUN:     if (cnt == len_q - ONE) next_state = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        rd_en = 1'b0;
        case (state)
            RUN: begin
                busy  = 1'b1;
                rd_en = !hold;
            end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    assign rd_addr = base_q + cnt[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        len_q  <= len;
                    end
                    cnt       <= '0;
                    drain_cnt <= '0;
                end
                RUN:     cnt <= cnt + ONE;
                DRAIN:   drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // A zero-length start finishes immediately; a held edge never emits the pulse.
    always_ff @(posedge clk) begin
        if (rst || hold) begin
            done <= 1'b0;
        end else begin
            done <= ((state == IDLE) && start && (len == '0)) ||
                    ((state == DRAIN) && (drain_cnt == DRAIN_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
        end else if (!hold) begin
            v0 <= (state == RUN);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam int LSB = lane_lsb(c, WIDTH);
        logic [WIDTH-1:0] lane_in;

        feed_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_bank (
            .clk    (clk),
            .wr_en  (wr_en && (wr_ch == CH_W'(c))),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .rd_en  (rd_en),
            .rd_addr(rd_addr),
            .rd_data(bank_q[c])
        );

        assign lane_in = v0 ? bank_q[c] : '0;

`ifdef SYSTOLIC_FEED_SKEW_EN
        if (c == 0) begin : g_direct
            assign out_valid[c]            = v0;
            assign out_data[LSB +: WIDTH]  = lane_in;
        end else begin : g_skew
            logic [c-1:0]     v_pipe;
            logic [WIDTH-1:0] d_pipe [c];

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_pipe <= '0;
                    for (int s = 0; s < c; s++) begin
                        d_pipe[s] <= '0;
                    end
                end else if (!hold) begin
                    v_pipe[0] <= v0;
                    d_pipe[0] <= lane_in;
                    for (int s = 1; s < c; s++) begin
                        v_pipe[s] <= v_pipe[s-1];
                        d_pipe[s] <= d_pipe[s-1];
                    end
                end
            end

            assign out_valid[c]           = v_pipe[c-1];
            assign out_data[LSB +: WIDTH] = d_pipe[c-1];
        end
`else
        assign out_valid[c]           = v0;
        assign out_data[LSB +: WIDTH] = lane_in;
`endif
    end

endmodule

// File: tb/tb_systolic_feed_ram.sv
// Self-checking bench for systolic_feed_ram: spec-level stream model plus directed literal checks.
module tb_systolic_feed_ram;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int CH = 2;
`ifdef SYSTOLIC_FEED_SKEW_EN
    localparam bit SKEW = 1'b1;
    localparam int DR   = CH;
`else
    localparam bit SKEW = 1'b0;
    localparam int DR   = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [0:0]    wr_ch;
    logic [3:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic [3:0]    base;
    logic [4:0]    len;
    logic          hold;
    logic          busy;
    logic          done;
    logic [CH-1:0] out_valid;
    logic [CH*W-1:0] out_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit checking  = 1'b0;

    systolic_feed_ram #(
        .WIDTH(W), .DEPTH(D), .ADDR_W(4), .CHANNELS(CH), .CH_W(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .base(base), .len(len), .hold(hold),
        .busy(busy), .done(done), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Stream model: k counts unheld edges since the accepted start (cycle T+k).
    logic [W-1:0] mem  [CH][D];
    logic [W-1:0] snap [CH][D];
    bit           m_active = 1'b0;
    bit           m_done0  = 1'b0;
    int           k        = 0;
    int           m_len    = 0;
    int           m_base   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_done0  = 1'b0;
            k        = 0;
        end else begin
            m_done0 = 1'b0;
            if (m_active && k == m_len + DR + 1) begin
                m_active = 1'b0;
            end else if (m_active && !hold) begin
                if (k <= m_len) begin
                    for (int c = 0; c < CH; c++) snap[c][k-1] = mem[c][(m_base + k - 1) % D];
                end
                k++;
            end
            if (!m_active && !hold && start) begin
                m_base = int'(base);
                m_len  = int'(len);
                if (len == 0) m_done0 = 1'b1;
                else begin
                    m_active = 1'b1;
                    k        = 1;
                end
            end
        end
        if (wr_en && int'(wr_ch) < CH) mem[wr_ch][wr_addr] = wr_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            logic [CH-1:0] ev;
            logic [W-1:0]  ed;
            int s;
            ev = '0;
            checkOutput("model_busy", 32'(busy), 32'(m_active && k <= m_len + DR));
            checkOutput("model_done", 32'(done), 32'(m_done0 || (m_active && k == m_len + DR + 1)));
            for (int c = 0; c < CH; c++) begin
                s = SKEW ? c : 0;
                ev[c] = m_active && k >= 2 + s && k <= m_len + 1 + s;
                ed = ev[c] ? snap[c][k-2-s] : '0;
                checkOutput($sformatf("model_data_lane%0d", c), 32'(out_data[c*W +: W]), 32'(ed));
            end
            checkOutput("model_valid", 32'(out_valid), 32'(ev));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic [4:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic writeWord(input logic [0:0] ch, input logic [3:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || done) && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) checkOutput("idle_timeout", 32'd1, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] e0 [8];
        logic [W-1:0] e1 [8];
        int edone;
        int dn;

        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base = '0; len = '0; hold = 1'b0;
        tick(); tick();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", out_data, 32'd0);
        rst = 1'b0;
        checking = 1'b1;

        writeWord(0, 0, 1); writeWord(0, 1, 4); writeWord(0, 2, 7); writeWord(0, 3, 2);
        writeWord(1, 0, 5); writeWord(1, 1, 8); writeWord(1, 2, 3); writeWord(1, 3, 6);
        tick();

        e0 = '{16'd0, 16'd1, 16'd4, 16'd7, 16'd2, 16'd0, 16'd0, 16'd0};
        if (SKEW) begin
            e1 = '{16'd0, 16'd0, 16'd5, 16'd8, 16'd3, 16'd6, 16'd0, 16'd0};
            edone = 7;
        end else begin
            e1 = '{16'd0, 16'd5, 16'd8, 16'd3, 16'd6, 16'd0, 16'd0, 16'd0};
            edone = 6;
        end

        $display("[TB] basic stream");
        applyStimulus(4'd0, 5'd4);
        for (int n = 1; n <= 8; n++) begin
            checkOutput($sformatf("basic_l0_c%0d", n), 32'(out_data[15:0]), 32'(e0[n-1]));
            checkOutput($sformatf("basic_l1_c%0d", n), 32'(out_data[31:16]), 32'(e1[n-1]));
            checkOutput($sformatf("basic_v_c%0d", n), 32'(out_valid), 32'({e1[n-1] != 0, e0[n-1] != 0}));
            checkOutput($sformatf("basic_done_c%0d", n), 32'(done), 32'(n == edone));
            tick();
        end
        waitIdle();

        $display("[TB] wrap");
        writeWord(0, 14, 11); writeWord(0, 15, 12); writeWord(1, 14, 13); writeWord(1, 15, 14);
        applyStimulus(4'd14, 5'd4);
        tick();
        checkOutput("wrap_l0_c2", 32'(out_data[15:0]), 32'd11);
        tick(); tick();
        checkOutput("wrap_l0_c4", 32'(out_data[15:0]), 32'd1);
        waitIdle();

        $display("[TB] zero length");
        applyStimulus(4'd5, 5'd0);
        checkOutput("len0_done", 32'(done), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd0);
        checkOutput("len0_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("len0_done_clear", 32'(done), 32'd0);
        tick();

        $display("[TB] hold");
        applyStimulus(4'd0, 5'd4);
        tick(); tick();
        checkOutput("hold_l0_c3", 32'(out_data[15:0]), 32'd4);
        hold = 1'b1;
        tick();
        checkOutput("hold_l0_frozen", 32'(out_data[15:0]), 32'd4);
        tick(); tick();
        hold = 1'b0;
        dn = 0;
        for (int n = 6; n <= 14; n++) begin
            if (done && dn == 0) dn = n;
            tick();
        end
        checkOutput("hold_done_cycle", 32'(dn), SKEW ? 32'd10 : 32'd9);
        waitIdle();

        $display("[TB] read during write");
        applyStimulus(4'd0, 5'd4);
        tick(); tick();
        writeWord(0, 2, 9);
        checkOutput("rdw_old_word", 32'(out_data[15:0]), 32'd7);
        waitIdle();
        applyStimulus(4'd0, 5'd4);
        tick(); tick(); tick();
        checkOutput("rdw_new_word", 32'(out_data[15:0]), 32'd9);
        waitIdle();

        $display("[TB] ignored start");
        applyStimulus(4'd0, 5'd4);
        tick();
        start = 1'b1; base = 4'd8; len = 5'd2;
        tick();
        start = 1'b0;
        tick(); tick();
        checkOutput("ignored_l0_c5", 32'(out_data[15:0]), 32'd2);
        waitIdle();

        $display("[TB] reset mid-stream");
        applyStimulus(4'd0, 5'd4);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        dn = 0;
        for (int n = 0; n < 6; n++) begin
            if (done) dn++;
            tick();
        end
        checkOutput("rst_no_done", 32'(dn), 32'd0);
        applyStimulus(4'd0, 5'd4);
        tick();
        checkOutput("rst_retained", 32'(out_data[15:0]), 32'd1);
        waitIdle();

        $display("[TB] start under hold in idle");
        hold = 1'b1;
        applyStimulus(4'd0, 5'd4);
        hold = 1'b0;
        checkOutput("hold_idle_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("hold_idle_busy2", 32'(busy), 32'd0);
        tick();

        checking = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
